// File: rtl/microsecond_alarm.sv
// One-shot/periodic alarm on the free-running microsecond count, with wrap-safe deadline compare.
// Define MICROSEC_ALARM_OVERRUN_EN to build the saturating late-periodic-expiry counter on O_OVERRUN.
module microsecond_alarm #(
    parameter int P_COUNTER_WIDTH = 32
) (
    input  logic                       I_CLK,
    input  logic                       I_NRESET,
    input  logic [P_COUNTER_WIDTH-1:0] I_MICROSEC_COUNT,
    input  logic                       I_START,
    input  logic [P_COUNTER_WIDTH-1:0] I_DURATION,
    input  logic                       I_PERIODIC,
    input  logic                       I_CANCEL,
    output logic                       O_BUSY,
    output logic                       O_EXPIRED,
    output logic [P_COUNTER_WIDTH-1:0] O_REMAINING,
    output logic [7:0]                 O_OVERRUN
);

    localparam int W = P_COUNTER_WIDTH;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;
    // Largest duration that keeps the sign bit of (count - deadline) meaningful.
    localparam logic [W-1:0] MAX_DUR = {1'b0, {(W-1){1'b1}}};

    logic [0:0]   state_r;
    logic [W-1:0] deadline_r;
    logic [W-1:0] period_r;
    logic         periodic_r;
    logic         expired_r;
    logic [W-1:0] remaining_r;

    logic [W-1:0] dur_s;
    logic [W-1:0] diff_s;
    logic [W-1:0] remain_s;
    logic         hit_s;

    // Duration clamp, signed-wrap distance to the deadline and the expiry test.
    always_comb begin
        dur_s    = I_DURATION;
        diff_s   = I_MICROSEC_COUNT - deadline_r;
        remain_s = {W{1'b0}} - diff_s;
        hit_s    = 1'b0;
        if (I_DURATION > MAX_DUR) begin
            dur_s = MAX_DUR;
        end else begin
            dur_s = I_DURATION;
        end
        if (state_r == ST_ARMED) begin
            hit_s = ~diff_s[W-1];
        end else begin
            hit_s = 1'b0;
        end
    end

    // Alarm state, deadline bookkeeping and registered outputs; cancel beats start beats expiry.
    always_ff @(posedge I_CLK) begin
        if (!I_NRESET) begin
            state_r     <= ST_IDLE;
            deadline_r  <= {W{1'b0}};
            period_r    <= {W{1'b0}};
            periodic_r  <= 1'b0;
            expired_r   <= 1'b0;
            remaining_r <= {W{1'b0}};
        end else begin
            expired_r <= 1'b0;
            if (I_CANCEL) begin
                state_r     <= ST_IDLE;
                remaining_r <= {W{1'b0}};
            end else if (I_START) begin
                state_r     <= ST_ARMED;
                deadline_r  <= I_MICROSEC_COUNT + dur_s;
                period_r    <= dur_s;
                periodic_r  <= I_PERIODIC;
                remaining_r <= dur_s;
            end else if (hit_s) begin
                expired_r   <= 1'b1;
                remaining_r <= {W{1'b0}};
                if (periodic_r) begin
                    // Advance from the old deadline, not from "now", so periods never drift.
                    deadline_r <= deadline_r + period_r;
                end else begin
                    state_r <= ST_IDLE;
                end
            end else if (state_r == ST_ARMED) begin
                remaining_r <= remain_s;
            end else begin
                remaining_r <= {W{1'b0}};
            end
        end
    end

`ifdef MICROSEC_ALARM_OVERRUN_EN
    logic [7:0] overrun_r;

    // Count periodic expiries that arrive a full period or more late; only reset clears it.
    always_ff @(posedge I_CLK) begin
        if (!I_NRESET) begin
            overrun_r <= 8'd0;
        end else if (!I_CANCEL && !I_START && hit_s && periodic_r &&
                     (diff_s >= period_r) && (overrun_r != 8'hFF)) begin
            overrun_r <= overrun_r + 8'd1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign O_OVERRUN = overrun_r;
`else
    assign O_OVERRUN = 8'd0;
`endif

    assign O_BUSY      = (state_r == ST_ARMED);
    assign O_EXPIRED   = expired_r;
    assign O_REMAINING = remaining_r;

endmodule

// File: doc/microsecond_alarm.md
# microsecond_alarm

Programmable one-shot/periodic alarm that consumes the free-running microsecond count produced by the FSS timebase and raises a single-cycle expiry pulse when a requested number of microseconds has elapsed. It sits beside the timebase in `fss_top` and lets control logic such as valve timing or debounce wait on real time instead of counting raw clock cycles. Deadline comparison is wrap-safe across counter roll-over.

## Interface
- `P_COUNTER_WIDTH`, 32: width of the microsecond count, durations, deadline and remaining-time output.
- `I_CLK` in 1: system clock, the same clock that drives the timebase.
- `I_NRESET` in 1: reset, synchronous, active-low.
- `I_MICROSEC_COUNT` in `P_COUNTER_WIDTH`: free-running microsecond count from the timebase. Monotonic, wraps.
- `I_START` in 1: arm request, sampled each cycle.
- `I_DURATION` in `P_COUNTER_WIDTH`: microseconds to wait, sampled with `I_START`.
- `I_PERIODIC` in 1: sampled with `I_START`. 1 re-arms automatically after each expiry.
- `I_CANCEL` in 1: disarm request.
- `O_BUSY` out 1: high while ARMED.
- `O_EXPIRED` out 1: one-cycle expiry pulse.
- `O_REMAINING` out `P_COUNTER_WIDTH`: microseconds until the deadline while ARMED, otherwise 0.
- `O_OVERRUN` out 8: saturating count of late periodic expiries. Tied to 0 unless `MICROSEC_ALARM_OVERRUN_EN` is defined.

## Operation
- States are IDLE and ARMED, with internal registers `deadline`, `period` and `periodic`.
- Duration clamp: the effective duration is `min(I_DURATION, 2^(W-1)-1)`, which keeps the signed wrap compare valid.
- Expired test: the MSB of `(I_MICROSEC_COUNT - deadline)` mod 2^W is 0.
- Priority each cycle: `I_CANCEL` > `I_START` > expiry.
- `I_CANCEL`:
  - Next state is IDLE.
  - No pulse, even if the expired test holds the same cycle.
  - `O_OVERRUN` keeps its value.
- `I_START` from any state:
  - `deadline <= I_MICROSEC_COUNT + dur`, `period <= dur`, `periodic <= I_PERIODIC`.
  - Next state is ARMED.
  - Re-arming while ARMED discards the old deadline without a pulse.
- ARMED with the expired test true:
  - `O_EXPIRED` pulses next cycle.
  - One-shot: go to IDLE.
  - Periodic: `deadline <= deadline + period` (drift-free) and stay ARMED.
- Periodic with `period == 0`: fires every cycle.
- IDLE: the expired test is ignored.
- All arithmetic is modulo 2^W. Sums are truncated.

## Timing
- Reset (sync, `I_NRESET` low at a clock edge): IDLE, `O_BUSY=0`, `O_EXPIRED=0`, `O_REMAINING=0`, `O_OVERRUN=0`, internal registers 0.
- Reset mid-operation aborts the alarm silently.
- Start accepted at edge N: `O_BUSY=1` from N+1.
- Expiry detected at edge K: `O_EXPIRED=1` for exactly cycle K+1.
  - One-shot: `O_BUSY=0` from K+1.
  - Periodic: `O_BUSY` stays 1.
- `O_REMAINING` is registered as `deadline - I_MICROSEC_COUNT` while ARMED, with one cycle of lag. It holds 0 at and after expiry, and 0 in IDLE.
- With D≥1, the pulse follows the first count value ≥ start count + D. Real elapsed time is between D-1 and D microseconds, because the start may land mid-microsecond.
- D=0: start at N, pulse at N+2.

## Configuration
- Macro `MICROSEC_ALARM_OVERRUN_EN`, defined: on each periodic expiry, if `(I_MICROSEC_COUNT - deadline) >= period`, `O_OVERRUN` increments, saturating at 255. Cleared only by reset.
- Not defined: `O_OVERRUN` is constant 0 and the overrun logic is not built. Alarm behaviour is otherwise identical.

## Test plan
- One-shot basic: count=100, start with D=5 -> `O_BUSY` high next cycle. Single `O_EXPIRED` pulse one cycle after the count reaches 105, then `O_BUSY=0`. `O_REMAINING` steps 5..0.
- Wrap-around: count=0xFFFF_FFFE, D=4 -> pulse after the count reaches 2. No early pulse at the wrap.
- Periodic: count=0, D=10, periodic -> pulses after counts 10, 20 and 30. Cancel at count 25 -> no pulse at 30, `O_BUSY=0`.
- Priority:
  - Cancel asserted in the same cycle the count hits the deadline -> no pulse.
  - Start while ARMED (old deadline 50, new start at count 40 with D=20) -> no pulse at 50, pulse after 60.
- Edge durations:
  - D=0 -> pulse two cycles after start.
  - D=0xFFFF_FFFF -> clamped to 0x7FFF_FFFF. Not expired immediately.
- Overrun (macro defined): periodic D=2, count jumped forward by 7 -> `O_OVERRUN` increments. Reset mid-ARMED -> all outputs 0 and no pulse afterwards.
